// File: rtl/sat_adder_tree.sv
// sat_adder_tree: pipelined saturating reduction of N_INPUTS signed lanes with valid/ready flow control.
// Define SAT_ADDER_TREE_BIAS_EN to add a registered saturating bias stage after the tree.
module sat_adder_tree #(
   parameter int WIDTH     = 32,
   parameter int N_INPUTS  = 8,
   parameter int CNT_WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [N_INPUTS*WIDTH-1:0]    in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
`ifdef SAT_ADDER_TREE_BIAS_EN
   input  logic [WIDTH-1:0]             bias,
`endif
   output logic [WIDTH-1:0]             out_data,
   output logic                         out_sat,
   output logic                         out_valid,
   input  logic                         out_ready,
   input  logic                         sat_clr,
   output logic [CNT_WIDTH-1:0]         sat_cnt
);

   localparam int STAGES = $clog2(N_INPUTS);

   // Returns {overflow, clamped sum}; overflow shows up as a disagreement between the
   // true sign (bit WIDTH) and the truncated sign (bit WIDTH-1) of the extended sum.
   function automatic logic [WIDTH:0] sat_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH:0] sum;
      sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
      if (sum[WIDTH] == sum[WIDTH-1]) begin
         return {1'b0, sum[WIDTH-1:0]};
      end else if (sum[WIDTH]) begin
         return {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
      end else begin
         return {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
      end
   endfunction

   logic adv;

   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      localparam int NODES = N_INPUTS >> (s + 1);

      logic [2*NODES*WIDTH-1:0] src;
      logic                     src_valid;
      logic                     src_sat;
      logic [NODES*WIDTH-1:0]   sum_w;
      logic [NODES-1:0]         ovf_w;
      logic [NODES*WIDTH-1:0]   node_d;
      logic [NODES*WIDTH-1:0]   node_q;
      logic                     valid_d;
      logic                     valid_q;
      logic                     sat_d;
      logic                     sat_q;

      if (s == 0) begin : g_src_in
         assign src       = in_data;
         assign src_valid = in_valid;
         assign src_sat   = 1'b0;
      end else begin : g_src_prev
         assign src       = g_stage[s-1].node_q;
         assign src_valid = g_stage[s-1].valid_q;
         assign src_sat   = g_stage[s-1].sat_q;
      end

      // Node j of this stage always combines nodes 2j and 2j+1 of the previous one.
      always_comb begin
         sum_w = '0;
         ovf_w = '0;
         for (int j = 0; j < NODES; j++) begin
            {ovf_w[j], sum_w[j*WIDTH +: WIDTH]} =
               sat_add(src[2*j*WIDTH +: WIDTH], src[(2*j+1)*WIDTH +: WIDTH]);
         end
      end

      always_comb begin
         node_d  = node_q;
         valid_d = valid_q;
         sat_d   = sat_q;
         if (adv) begin
            node_d  = sum_w;
            valid_d = src_valid;
            sat_d   = src_sat | (|ovf_w);
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            node_q  <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
         end else begin
            node_q  <= node_d;
            valid_q <= valid_d;
            sat_q   <= sat_d;
         end
      end
   end

   logic [WIDTH-1:0] tree_data;
   logic             tree_valid;
   logic             tree_sat;

   assign tree_data  = g_stage[STAGES-1].node_q;
   assign tree_valid = g_stage[STAGES-1].valid_q;
   assign tree_sat   = g_stage[STAGES-1].sat_q;

`ifdef SAT_ADDER_TREE_BIAS_EN
   logic [WIDTH:0]   bias_sum;
   logic [WIDTH-1:0] bias_data_d;
   logic [WIDTH-1:0] bias_data_q;
   logic             bias_valid_d;
   logic             bias_valid_q;
   logic             bias_sat_d;
   logic             bias_sat_q;

   assign bias_sum = sat_add(tree_data, bias);

   always_comb begin
      bias_data_d  = bias_data_q;
      bias_valid_d = bias_valid_q;
      bias_sat_d   = bias_sat_q;
      if (adv) begin
         bias_data_d  = bias_sum[WIDTH-1:0];
         bias_valid_d = tree_valid;
         bias_sat_d   = tree_sat | bias_sum[WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bias_data_q  <= '0;
         bias_valid_q <= 1'b0;
         bias_sat_q   <= 1'b0;
      end else begin
         bias_data_q  <= bias_data_d;
         bias_valid_q <= bias_valid_d;
         bias_sat_q   <= bias_sat_d;
      end
   end

   assign out_data  = bias_data_q;
   assign out_valid = bias_valid_q;
   assign out_sat   = bias_sat_q;
`else
   assign out_data  = tree_data;
   assign out_valid = tree_valid;
   assign out_sat   = tree_sat;
`endif

   logic [CNT_WIDTH-1:0] sat_cnt_d;
   logic [CNT_WIDTH-1:0] sat_cnt_q;

   // Clear beats a same-cycle increment; the count sticks at all-ones.
   always_comb begin
      sat_cnt_d = sat_cnt_q;
      if (sat_clr) begin
         sat_cnt_d = '0;
      end else if (out_valid && out_ready && out_sat && !(&sat_cnt_q)) begin
         sat_cnt_d = sat_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sat_cnt_q <= '0;
      end else begin
         sat_cnt_q <= sat_cnt_d;
      end
   end

   assign sat_cnt = sat_cnt_q;

endmodule

// File: tb/tb_sat_adder_tree.sv
// tb_sat_adder_tree: directed steps plus a queue scoreboard and counter model for sat_adder_tree (WIDTH=16, N=4).
// Honours SAT_ADDER_TREE_BIAS_EN when the design is built with the bias stage.
module tb_sat_adder_tree;

   localparam int W  = 16;
   localparam int N  = 4;
   localparam int CW = 8;
`ifdef SAT_ADDER_TREE_BIAS_EN
   localparam bit BIAS_ON = 1'b1;
`else
   localparam bit BIAS_ON = 1'b0;
`endif
   localparam int LAT = 2 + (BIAS_ON ? 1 : 0);
   localparam int MAXV = 2**(W-1) - 1;
   localparam int MINV = -(2**(W-1));
   localparam logic [W-1:0] BIAS_VAL = 16'hFFF6;
   localparam logic [N*W-1:0] SAT_LANES = {16'h7000, 16'h7000, 16'h7000, 16'h7000};

   logic            clk;
   logic            rst_n;
   logic [N*W-1:0]  in_data;
   logic            in_valid;
   logic            in_ready;
   logic [W-1:0]    bias_sig;
   logic [W-1:0]    out_data;
   logic            out_sat;
   logic            out_valid;
   logic            out_ready;
   logic            sat_clr;
   logic [CW-1:0]   sat_cnt;

   int test_count = 0;
   int fail_count = 0;
   int pop_count  = 0;
   logic [W:0]    sb [$];
   logic [W:0]    mon_exp;
   logic [CW-1:0] cnt_model = '0;
   bit            mon_on = 1'b0;
   logic [N*W-1:0] items [8];

   sat_adder_tree #(.WIDTH(W), .N_INPUTS(N), .CNT_WIDTH(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
`ifdef SAT_ADDER_TREE_BIAS_EN
      .bias      (bias_sig),
`endif
      .out_data  (out_data),
      .out_sat   (out_sat),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sat_clr   (sat_clr),
      .sat_cnt   (sat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W:0] satAdd(input logic [W-1:0] a, input logic [W-1:0] b);
      int s;
      s = int'($signed(a)) + int'($signed(b));
      if (s > MAXV) return {1'b1, W'(MAXV)};
      if (s < MINV) return {1'b1, W'(MINV)};
      return {1'b0, W'(s)};
   endfunction

   function automatic logic [W:0] modelTree(input logic [N*W-1:0] lanes);
      logic [W-1:0] node [N];
      logic [W:0]   r;
      logic         sat;
      sat = 1'b0;
      for (int i = 0; i < N; i++) node[i] = lanes[i*W +: W];
      for (int n = N; n > 1; n = n / 2) begin
         for (int j = 0; j < n / 2; j++) begin
            r = satAdd(node[2*j], node[2*j+1]);
            node[j] = r[W-1:0];
            sat |= r[W];
         end
      end
      if (BIAS_ON) begin
         r = satAdd(node[0], BIAS_VAL);
         node[0] = r[W-1:0];
         sat |= r[W];
      end
      return {sat, node[0]};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      test_count++;
      assert (observed === expected) else begin
         fail_count++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [N*W-1:0] lanes);
      in_data  = lanes;
      in_valid = 1'b1;
   endtask

   // One item through an otherwise idle pipe: exact latency, result, then the counter after transfer.
   task automatic runSingle(input string tag, input logic [N*W-1:0] lanes,
                            input logic [W-1:0] exp_data, input logic exp_sat, input logic [CW-1:0] exp_cnt);
      applyStimulus(lanes);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 1; k < LAT; k++) begin
         checkOutput({tag, "_early"}, 32'(out_valid), 32'd0);
         @(posedge clk); #1;
      end
      checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, "_data"}, 32'(out_data), 32'(exp_data));
      checkOutput({tag, "_sat"}, 32'(out_sat), 32'(exp_sat));
      @(posedge clk); #1;
      checkOutput({tag, "_cnt"}, 32'(sat_cnt), 32'(exp_cnt));
   endtask

   // Scoreboard: push on input transfer, pop and compare on output transfer, track the counter.
   always @(negedge clk) begin
      if (mon_on) begin
         checkOutput("mon_sat_cnt", 32'(sat_cnt), 32'(cnt_model));
         if (!rst_n) begin
            sb.delete();
            cnt_model = '0;
         end else begin
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  checkOutput("mon_stale_out", 32'(out_valid), 32'd0);
               end else begin
                  mon_exp = sb.pop_front();
                  pop_count++;
                  checkOutput("mon_data", 32'(out_data), 32'(mon_exp[W-1:0]));
                  checkOutput("mon_sat", 32'(out_sat), 32'(mon_exp[W]));
                  if (mon_exp[W] && cnt_model != '1) cnt_model = cnt_model + 1'b1;
               end
            end
            if (sat_clr) cnt_model = '0;
            if (in_valid && in_ready) sb.push_back(modelTree(in_data));
         end
      end
   end

   initial begin
      int  idx;
      int  cyc;
      int  pops_before;
      bit  hs;

      bias_sig  = BIAS_VAL;
      rst_n     = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      sat_clr   = 1'b0;
      for (int i = 0; i < 8; i++) items[i] = {$urandom, $urandom};

      @(posedge clk); #1;
      mon_on = 1'b1;
      @(posedge clk); #1;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_data", 32'(out_data), 32'd0);
      checkOutput("rst_out_sat", 32'(out_sat), 32'd0);
      checkOutput("rst_sat_cnt", 32'(sat_cnt), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

      runSingle("sum_1234", {16'd4, 16'd3, 16'd2, 16'd1}, BIAS_ON ? 16'h0000 : 16'd10, 1'b0, 8'd0);
      runSingle("pos_clamp", {16'd1, 16'd1, 16'h7000, 16'h7000}, BIAS_ON ? 16'h7FF5 : 16'h7FFF, 1'b1, 8'd1);
      runSingle("neg_clamp", {16'h0000, 16'h0000, 16'hFFFF, 16'h8000}, 16'h8000, 1'b1, 8'd2);
      runSingle("pair_order", {16'h0000, 16'h8000, 16'h0001, 16'h7FFF}, BIAS_ON ? 16'hFFF5 : 16'hFFFF, 1'b1, 8'd3);
      runSingle("ones", {16'd1, 16'd1, 16'd1, 16'd1}, BIAS_ON ? 16'hFFFA : 16'h0004, 1'b0, 8'd3);

      // Back-to-back stream with out_ready dropped for cycles 4..6.
      pops_before = pop_count;
      idx = 0;
      cyc = 0;
      while (idx < 8 && cyc < 100) begin
         applyStimulus(items[idx]);
         out_ready = !(cyc >= 4 && cyc < 7);
         #1;
         checkOutput($sformatf("stream_in_ready_c%0d", cyc), 32'(in_ready), 32'(out_ready));
         if (!out_ready) checkOutput($sformatf("stream_hold_valid_c%0d", cyc), 32'(out_valid), 32'd1);
         hs = in_ready;
         @(posedge clk); #1;
         if (hs) idx++;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checkOutput("stream_accepted", 32'(idx), 32'd8);
      for (int k = 0; k < 20 && sb.size() != 0; k++) begin
         @(posedge clk); #1;
      end
      checkOutput("stream_drained", 32'(sb.size()), 32'd0);
      checkOutput("stream_pops", 32'(pop_count - pops_before), 32'd8);

      applyStimulus(SAT_LANES);
      repeat (270) @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (LAT + 2) @(posedge clk);
      #1;
      checkOutput("cnt_saturated", 32'(sat_cnt), 32'hFF);
      runSingle("cnt_hold", SAT_LANES, BIAS_ON ? 16'h7FF5 : 16'h7FFF, 1'b1, 8'hFF);

      applyStimulus(SAT_LANES);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 0; k < 10 && !out_valid; k++) begin
         @(posedge clk); #1;
      end
      checkOutput("clr_wait_valid", 32'(out_valid), 32'd1);
      sat_clr = 1'b1;
      @(posedge clk); #1;
      sat_clr = 1'b0;
      checkOutput("clr_priority", 32'(sat_cnt), 32'd0);

      applyStimulus({16'd7, 16'd6, 16'd5, 16'd4});
      @(posedge clk); #1;
      applyStimulus({16'h7000, 16'h7000, 16'd9, 16'd8});
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(posedge clk); #1;
      checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("midrst_out_data", 32'(out_data), 32'd0);
      checkOutput("midrst_out_sat", 32'(out_sat), 32'd0);
      checkOutput("midrst_sat_cnt", 32'(sat_cnt), 32'd0);
      rst_n = 1'b1;
      checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         checkOutput($sformatf("midrst_no_stale_%0d", k), 32'(out_valid), 32'd0);
      end

      runSingle("post_rst", {16'd1, 16'd2, 16'd3, 16'd4}, BIAS_ON ? 16'h0000 : 16'd10, 1'b0, 8'd0);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
